dmem_arbiter: RTL and testbench

//   Shares the single-port 16-bit data memory between two requesters: the CPU

---
 rtl/dmem_arbiter.sv | 67 ++++++
 tb/tb_dmem_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin/lockable sharing of one data-memory port between CPU (C) and loader (L),
// with read-return tagging across the memory read latency.
module dmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic              rr_ptr;
    logic              owner_lock;
    logic              lock_hold;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_l;
    // lock only persists while L keeps both req and lock; otherwise C arbitrates normally
    assign lock_hold = owner_lock & l_req & l_lock;
    assign l_gnt     = ~rst & l_req & (lock_hold | ~c_req | rr_ptr);
    assign c_gnt     = ~rst & c_req & ~lock_hold & (~l_req | ~rr_ptr);
    assign c_stall   = ~rst & c_req & ~c_gnt;
    assign mem_en    = c_gnt | l_gnt;
    assign mem_we    = c_gnt ? c_we : l_gnt & l_we;
    assign mem_addr  = c_gnt ? c_addr : l_gnt ? l_addr : '0;
    assign mem_wdata = c_gnt ? c_wdata : l_gnt ? l_wdata : '0;
    assign c_rvalid  = ~rst & tag_v[RD_LAT-1] & ~tag_l[RD_LAT-1];
    assign l_rvalid  = ~rst & tag_v[RD_LAT-1] & tag_l[RD_LAT-1];
    assign c_rdata   = c_rvalid ? mem_rdata : '0;
    assign l_rdata   = l_rvalid ? mem_rdata : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 1'b0;
            owner_lock <= 1'b0;
            tag_v      <= '0;
            tag_l      <= '0;
        end else begin
            if (mem_en) rr_ptr <= c_gnt;
            owner_lock <= l_gnt & l_lock;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_v[i] <= tag_v[i-1];
                tag_l[i] <= tag_l[i-1];
            end
            tag_v[0] <= mem_en & ~mem_we;
            tag_l[0] <= l_gnt;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven cycle vectors plus a hand-written reset/flush sequence,
// with a behavioural 3-cycle-latency memory behind the arbiter.
module tb_dmem_arbiter;
    localparam int LAT = 3;
    logic clk = 1'b0;
    logic rst;
    logic c_req, c_we, c_gnt, c_rvalid, c_stall;
    logic [15:0] c_addr, c_wdata, c_rdata;
    logic l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [15:0] l_addr, l_wdata, l_rdata;
    logic mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] mem [0:1023];
    logic [15:0] rp [0:LAT-1];
    logic [70:0] act;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic creq, cwe, lreq, lwe, llock;
        logic [15:0] caddr, cwd, laddr, lwd;
        logic [70:0] exp;
    } vec_t;
    vec_t tbl[$];

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en & mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        rp[0] <= (mem_en & ~mem_we) ? mem[mem_addr[9:0]] : 16'hDEAD;
        for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end
    assign mem_rdata = rp[LAT-1];

    assign act = {c_gnt, l_gnt, c_stall, mem_en, mem_we, mem_addr, mem_wdata,
                  c_rvalid, c_rdata, l_rvalid, l_rdata};

    task automatic chk(input string nm, input logic [70:0] a, input logic [70:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    function automatic void add(input int creq, cwe, caddr, cwd, lreq, lwe, llock, laddr, lwd,
                                input int cg, lg, cs, en, we, addr, wd, crv, crd, lrv, lrd);
        vec_t v;
        int ta, tw, tc, tl;
        ta = addr; tw = wd; tc = crd; tl = lrd;
        v.creq = creq[0]; v.cwe = cwe[0]; v.caddr = caddr[15:0]; v.cwd = cwd[15:0];
        v.lreq = lreq[0]; v.lwe = lwe[0]; v.llock = llock[0];
        v.laddr = laddr[15:0]; v.lwd = lwd[15:0];
        v.exp = {cg[0], lg[0], cs[0], en[0], we[0], ta[15:0], tw[15:0],
                 crv[0], tc[15:0], lrv[0], tl[15:0]};
        tbl.push_back(v);
    endfunction

    function automatic void idle(input int crv, crd, lrv, lrd);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, crv, crd, lrv, lrd);
    endfunction

    initial begin
        rst = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010; c_wdata = '0;
        l_req = 1'b1; l_we = 1'b0; l_lock = 1'b0; l_addr = 16'h0004; l_wdata = '0;
        // C write then read back
        add(1, 1, 'h0010, 'hBEEF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 'h0010, 'hBEEF, 0, 0, 0, 0);
        add(1, 0, 'h0010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 'h0010, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0);
        idle(0, 0, 0, 0);
        idle(1, 'hBEEF, 0, 0);
        // preload, then both ports reading every cycle
        add(1, 1, 'h0002, 'h1111, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 'h0002, 'h1111, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 'h0004, 'h2222, 0, 1, 0, 1, 1, 'h0004, 'h2222, 0, 0, 0, 0);
        add(1, 0, 'h0002, 0, 1, 0, 0, 'h0004, 0, 1, 0, 0, 1, 0, 'h0002, 0, 0, 0, 0, 0);
        add(1, 0, 'h0002, 0, 1, 0, 0, 'h0004, 0, 0, 1, 1, 1, 0, 'h0004, 0, 0, 0, 0, 0);
        add(1, 0, 'h0002, 0, 1, 0, 0, 'h0004, 0, 1, 0, 0, 1, 0, 'h0002, 0, 0, 0, 0, 0);
        add(1, 0, 'h0002, 0, 1, 0, 0, 'h0004, 0, 0, 1, 1, 1, 0, 'h0004, 0, 1, 'h1111, 0, 0);
        idle(0, 0, 1, 'h2222);
        idle(1, 'h1111, 0, 0);
        idle(0, 0, 1, 'h2222);
        // C write points rr at L, then locked L burst while C waits
        add(1, 1, 'h0020, 'h5555, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 'h0020, 'h5555, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            add(1, 0, 'h0010, 0, 1, 1, 1, 'h0100 + k, 'hA000 + k, 0, 1, 1, 1, 1, 'h0100 + k, 'hA000 + k, 0, 0, 0, 0);
        add(1, 0, 'h0010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 'h0010, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0);
        idle(0, 0, 0, 0);
        idle(1, 'hBEEF, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 'h0100, 0, 0, 1, 0, 1, 0, 'h0100, 0, 0, 0, 0, 0);
        add(1, 0, 'h0103, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 'h0103, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0);
        idle(0, 0, 1, 'hA000);
        idle(1, 'hA003, 0, 0);
        // 10 idle cycles must leave rr pointing at L
        for (int k = 0; k < 10; k++) idle(0, 0, 0, 0);
        add(1, 0, 'h0002, 0, 1, 0, 0, 'h0004, 0, 0, 1, 1, 1, 0, 'h0004, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0);
        idle(0, 0, 0, 0);
        idle(0, 0, 1, 'h2222);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", act, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        foreach (tbl[i]) begin
            c_req = tbl[i].creq; c_we = tbl[i].cwe; c_addr = tbl[i].caddr; c_wdata = tbl[i].cwd;
            l_req = tbl[i].lreq; l_we = tbl[i].lwe; l_lock = tbl[i].llock;
            l_addr = tbl[i].laddr; l_wdata = tbl[i].lwd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), act, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // reset one cycle after a C read grant: read must never return, rr back to C
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010; c_wdata = '0; l_req = 1'b0; l_lock = 1'b0;
        @(negedge clk);
        chk("rst_pre_gnt", 71'(c_gnt), 71'(1));
        @(posedge clk);
        #1 rst = 1'b1; l_req = 1'b1; l_addr = 16'h0004;
        @(negedge clk);
        chk("rst_outputs", act, '0);
        @(posedge clk);
        #1 rst = 1'b0; c_req = 1'b0; l_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_flush%0d", k), 71'({c_rvalid, l_rvalid, c_rdata}), '0);
            @(posedge clk);
            #1;
        end
        c_req = 1'b1; l_req = 1'b1;
        @(negedge clk);
        chk("rst_rr_c_first", 71'({c_gnt, l_gnt, c_stall}), 71'(3'b100));
        @(posedge clk);
        #1 c_req = 1'b0; l_req = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
